// File: rtl/rf_dual_wr_if.sv
// Bus bundle for the dual-write register file: write ports, read ports, scoreboard mark
// and busy outputs. The master drives requests; the slave is the register file.
interface rf_dual_wr_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              regwr0;
    logic [ADDR_W-1:0] wr0;
    logic [DATA_W-1:0] wd0;
    logic              regwr1;
    logic [ADDR_W-1:0] wr1;
    logic [DATA_W-1:0] wd1;
    logic [ADDR_W-1:0] rr1;
    logic [ADDR_W-1:0] rr2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              mark;
    logic [ADDR_W-1:0] mark_addr;
    logic              rd1_busy;
    logic              rd2_busy;
    logic [ADDR_W:0]   busy_cnt;

    modport master (
        output regwr0, wr0, wd0, regwr1, wr1, wd1, rr1, rr2, mark, mark_addr,
        input  rd1, rd2, rd1_busy, rd2_busy, busy_cnt
    );

    modport slave (
        input  regwr0, wr0, wd0, regwr1, wr1, wd1, rr1, rr2, mark, mark_addr,
        output rd1, rd2, rd1_busy, rd2_busy, busy_cnt
    );
endinterface

// File: rtl/rf_dual_wr.sv
// Two-read / two-write register file with per-register busy scoreboard and popcount.
// Optional macro RF_BYPASS_EN adds same-cycle write-to-read forwarding.
module rf_dual_wr #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic        clk,
    input  logic        rst,
    rf_dual_wr_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [ADDR_W:0]   r_busy_cnt;

    logic [DEPTH-1:0]  w_busy_nxt;
    logic [ADDR_W:0]   w_busy_cnt_nxt;
    logic [1:0]        w_inc;
    logic [1:0]        w_dec;
    logic [ADDR_W-1:0] w_rr [2];
    logic [DATA_W-1:0] w_rd [2];
    logic              w_rbusy [2];

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Set beats clear: a mark in the same cycle as a write means a newer producer is pending.
    always_comb begin
        w_busy_nxt = r_busy;
        w_inc      = '0;
        w_dec      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.mark && bus.mark_addr == ADDR_W'(i))
                w_busy_nxt[i] = 1'b1;
            else if ((bus.regwr0 && bus.wr0 == ADDR_W'(i)) ||
                     (bus.regwr1 && bus.wr1 == ADDR_W'(i)))
                w_busy_nxt[i] = 1'b0;
            if (ZERO_REG != 0 && i == 0)
                w_busy_nxt[i] = 1'b0;
            if (!r_busy[i] && w_busy_nxt[i])
                w_inc = w_inc + 2'd1;
            if (r_busy[i] && !w_busy_nxt[i])
                w_dec = w_dec + 2'd1;
        end
        w_busy_cnt_nxt = r_busy_cnt + (ADDR_W+1)'(w_inc) - (ADDR_W+1)'(w_dec);
    end

    assign w_rr[0] = bus.rr1;
    assign w_rr[1] = bus.rr2;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_rd[k]    = r_mem[w_rr[k]];
            w_rbusy[k] = r_busy[w_rr[k]];
`ifdef RF_BYPASS_EN
            // Port 1 is checked first so it wins when both write ports hit this read address.
            if (bus.regwr1 && bus.wr1 == w_rr[k]) begin
                w_rd[k]    = bus.wd1;
                w_rbusy[k] = bus.mark && bus.mark_addr == w_rr[k];
            end else if (bus.regwr0 && bus.wr0 == w_rr[k]) begin
                w_rd[k]    = bus.wd0;
                w_rbusy[k] = bus.mark && bus.mark_addr == w_rr[k];
            end
`endif
            if (is_zero(w_rr[k])) begin
                w_rd[k]    = '0;
                w_rbusy[k] = 1'b0;
            end
        end
    end

    assign bus.rd1      = w_rd[0];
    assign bus.rd2      = w_rd[1];
    assign bus.rd1_busy = w_rbusy[0];
    assign bus.rd2_busy = w_rbusy[1];
    assign bus.busy_cnt = r_busy_cnt;

    // Port 1 write is issued after port 0 so a same-address collision keeps port 1's data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            if (bus.regwr0 && !is_zero(bus.wr0))
                r_mem[bus.wr0] <= bus.wd0;
            if (bus.regwr1 && !is_zero(bus.wr1))
                r_mem[bus.wr1] <= bus.wd1;
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_busy_cnt_nxt;
        end
    end
endmodule

// File: tb/tb_rf_dual_wr.sv
// Bench for rf_dual_wr: directed steps followed by random traffic, all outputs compared
// every cycle against an array-based reference model.
module tb_rf_dual_wr;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rf_dual_wr_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rf_dual_wr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DATA_W-1:0] m_mem [DEPTH];
    bit                m_busy [DEPTH];
    bit                m_valid = 1'b0;
    int                n_vec = 0;
    int                n_err = 0;
    string             phase = "init";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] a);
        if (a == 0) return '0;
`ifdef RF_BYPASS_EN
        if (bus.regwr1 && bus.wr1 == a) return bus.wd1;
        if (bus.regwr0 && bus.wr0 == a) return bus.wd0;
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [ADDR_W-1:0] a);
        if (a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
        if ((bus.regwr1 && bus.wr1 == a) || (bus.regwr0 && bus.wr0 == a))
            return bus.mark && bus.mark_addr == a;
`endif
        return m_busy[a];
    endfunction

    function automatic int popcount();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic idle();
        bus.regwr0 = 0; bus.wr0 = '0; bus.wd0 = '0;
        bus.regwr1 = 0; bus.wr1 = '0; bus.wd1 = '0;
        bus.mark = 0; bus.mark_addr = '0;
    endtask

    // Called on the falling edge with inputs already driven: check, clock, update model.
    task automatic step();
        #1;
        if (m_valid) begin
            chk("rd1", bus.rd1, exp_rd(bus.rr1));
            chk("rd2", bus.rd2, exp_rd(bus.rr2));
            chk("rd1_busy", 32'(bus.rd1_busy), 32'(exp_busy(bus.rr1)));
            chk("rd2_busy", 32'(bus.rd2_busy), 32'(exp_busy(bus.rr2)));
            chk("busy_cnt", 32'(bus.busy_cnt), 32'(popcount()));
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i] = '0;
                m_busy[i] = 1'b0;
            end
            m_valid = 1'b1;
        end else begin
            if (bus.regwr0 && bus.wr0 != 0) m_mem[bus.wr0] = bus.wd0;
            if (bus.regwr1 && bus.wr1 != 0) m_mem[bus.wr1] = bus.wd1;
            if (bus.regwr0) m_busy[bus.wr0] = 1'b0;
            if (bus.regwr1) m_busy[bus.wr1] = 1'b0;
            if (bus.mark && bus.mark_addr != 0) m_busy[bus.mark_addr] = 1'b1;
        end
        @(negedge clk);
    endtask

    function automatic logic [ADDR_W-1:0] raddr();
        if ($urandom % 2) return ADDR_W'($urandom_range(0, 7));
        return ADDR_W'($urandom_range(0, DEPTH - 1));
    endfunction

    initial begin
        idle();
        bus.rr1 = '0; bus.rr2 = '0;
        @(negedge clk);

        phase = "reset";
        rst = 1; step(); step(); rst = 0;
        bus.rr1 = 5'd2; bus.rr2 = 5'd31;
        #1;
        chk("rd1", bus.rd1, 32'h0);
        chk("rd2", bus.rd2, 32'h0);
        chk("busy_cnt", 32'(bus.busy_cnt), 32'd0);
        step();

        phase = "dual_write";
        bus.regwr0 = 1; bus.wr0 = 5'd4; bus.wd0 = 32'h01;
        bus.regwr1 = 1; bus.wr1 = 5'd5; bus.wd1 = 32'hDEADBEEF;
        step(); idle();
        bus.rr1 = 5'd4; bus.rr2 = 5'd5;
        #1;
        chk("rd1", bus.rd1, 32'h01);
        chk("rd2", bus.rd2, 32'hDEADBEEF);
        step();

        phase = "collision";
        bus.regwr0 = 1; bus.wr0 = 5'd7; bus.wd0 = 32'h11;
        bus.regwr1 = 1; bus.wr1 = 5'd7; bus.wd1 = 32'h22;
        step(); idle();
        bus.rr1 = 5'd7;
        #1;
        chk("rd1", bus.rd1, 32'h22);
        step();

        phase = "zero_reg";
        bus.regwr0 = 1; bus.wr0 = 5'd0; bus.wd0 = 32'hFFFFFFFF;
        bus.mark = 1; bus.mark_addr = 5'd0; bus.rr1 = 5'd0;
        step(); idle();
        #1;
        chk("rd1", bus.rd1, 32'h0);
        chk("rd1_busy", 32'(bus.rd1_busy), 32'd0);
        chk("busy_cnt", 32'(bus.busy_cnt), 32'd0);
        step();

        phase = "same_cycle_read";
        bus.regwr0 = 1; bus.wr0 = 5'd6; bus.wd0 = 32'hA5; bus.rr1 = 5'd6;
        #1;
`ifdef RF_BYPASS_EN
        chk("rd1", bus.rd1, 32'hA5);
`else
        chk("rd1", bus.rd1, 32'h0);
`endif
        step(); idle();
        #1;
        chk("rd1", bus.rd1, 32'hA5);
        step();

        phase = "scoreboard";
        bus.mark = 1; bus.mark_addr = 5'd3; step();
        bus.mark_addr = 5'd9; step(); idle();
        bus.rr1 = 5'd3;
        #1;
        chk("busy_cnt", 32'(bus.busy_cnt), 32'd2);
        chk("rd1_busy", 32'(bus.rd1_busy), 32'd1);
        bus.regwr0 = 1; bus.wr0 = 5'd3; bus.wd0 = 32'h33;
        bus.mark = 1; bus.mark_addr = 5'd3;
        step(); idle();
        #1;
        chk("busy_cnt", 32'(bus.busy_cnt), 32'd2);
        bus.regwr1 = 1; bus.wr1 = 5'd9; bus.wd1 = 32'h99;
        step(); idle();
        #1;
        chk("busy_cnt", 32'(bus.busy_cnt), 32'd1);
        rst = 1; step(); rst = 0;
        #1;
        chk("busy_cnt", 32'(bus.busy_cnt), 32'd0);
        step();

        phase = "random";
        for (int n = 0; n < 600; n++) begin
            rst            = ($urandom_range(0, 79) == 0);
            bus.regwr0     = 1'($urandom % 2);
            bus.wr0        = raddr();
            bus.wd0        = $urandom;
            bus.regwr1     = 1'($urandom % 2);
            bus.wr1        = raddr();
            bus.wd1        = $urandom;
            bus.mark       = 1'($urandom_range(0, 2) != 0);
            bus.mark_addr  = raddr();
            bus.rr1        = raddr();
            bus.rr2        = raddr();
            step();
        end
        rst = 0; idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rf_dual_wr.md
Name: rf_dual_wr

Overview:
- Parametrised successor to the single-write CPU register file.
- Provides 2 combinational read ports, 2 synchronous write ports, hardwired zero register, and a per-register busy scoreboard.
- The scoreboard lets multi-issue or out-of-order datapaths detect pending writes.
- Sits in the decode/writeback stages between the pipeline registers and the hazard unit.

Parameters:
- DATA_W, 32, width of each register.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- ZERO_REG, 1, when 1, register 0 reads as zero, ignores writes and is never busy.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- regwr0  in  1  write enable, port 0
- wr0  in  ADDR_W  write address, port 0
- wd0  in  DATA_W  write data, port 0
- regwr1  in  1  write enable, port 1
- wr1  in  ADDR_W  write address, port 1
- wd1  in  DATA_W  write data, port 1
- rr1  in  ADDR_W  read address, port 1
- rr2  in  ADDR_W  read address, port 2
- rd1  out  DATA_W  read data, port 1 (combinational)
- rd2  out  DATA_W  read data, port 2 (combinational)
- mark  in  1  set busy bit of mark_addr (producer issued)
- mark_addr  in  ADDR_W  register to mark busy
- rd1_busy  out  1  busy bit of rr1 (combinational)
- rd2_busy  out  1  busy bit of rr2 (combinational)
- busy_cnt  out  ADDR_W+1  number of busy registers (registered)

Behaviour:
- Reset:
  - Synchronous, active-high: clk is the only clock; rst sampled on rising edge of clk.
  - When rst=1 at an edge, all registers clear to 0, all busy bits clear, and busy_cnt goes to 0.
  - rst overrides writes and mark in the same cycle.
  - Reset mid-operation drops all pending busy state.
- Writes:
  - Committed on the rising edge; the new value is visible on rd1/rd2 from the next cycle.
  - Same-address simultaneous write (regwr0=regwr1=1, wr0==wr1): port 1 wins, port 0 is discarded.
- Reads:
  - rd1 = reg[rr1], rd2 = reg[rr2], purely combinational.
  - With ZERO_REG=1, address 0 returns 0 regardless of storage.
- Busy scoreboard:
  - A write on either port clears busy[addr] at the edge.
  - mark sets busy[mark_addr] at the edge.
  - mark and write to the same address in the same cycle: set wins, busy stays 1 (a newer producer is outstanding).
  - With ZERO_REG=1: mark_addr=0 is ignored, and writes to 0 change nothing.
- busy_cnt:
  - Popcount of busy bits after the edge, maintained incrementally: +1 per 0->1 transition, -1 per 1->0 transition.
  - Range 0..2**ADDR_W; it never wraps because the count is bounded by depth.
- Busy outputs: rd1_busy/rd2_busy reflect current (registered) busy bits and do not see same-cycle mark or write.
- No X on outputs after the first reset edge; before the first reset, contents are undefined.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - Write-to-read forwarding: if regwrN=1 and wrN==rrK (and not the zero register), rdK returns wdN in the same cycle.
  - Port 1 data takes priority when both ports match.
  - rdK_busy is forced to 0 when the bypass supplies rdK, unless mark targets the same address in the same cycle, in which case busy stays 1.
- Undefined:
  - Reads return stored contents only; the new value appears one cycle later.
  - No forwarding mux is generated.

Test Plan:
1. Reset state: assert rst for 2 cycles, then read rr1=2, rr2=31 -> rd1=0, rd2=0, rd1_busy=rd2_busy=0, busy_cnt=0.
2. Dual write, different addresses: regwr0 wr0=4 wd0=32'h01, regwr1 wr1=5 wd1=32'hDEADBEEF, then next cycle rr1=4, rr2=5 -> rd1=32'h01, rd2=32'hDEADBEEF.
3. Write collision: wr0=wr1=7 with wd0=32'h11, wd1=32'h22 -> next cycle rr1=7 gives 32'h22.
4. Zero register: write 32'hFFFFFFFF to addr 0 and mark addr 0 -> rd1(rr1=0)=0, rd1_busy=0, busy_cnt=0.
5. Scoreboard sequence:
   - mark 3, then mark 9 -> busy_cnt=2, rd1_busy(rr1=3)=1.
   - write 3 together with mark 3 in the same cycle -> busy_cnt stays 2.
   - write 9 -> busy_cnt=1.
   - assert rst -> busy_cnt=0.
6. Same-cycle read of a register being written (wr0=rr1=6, wd0=32'hA5):
   - RF_BYPASS_EN defined -> rd1=32'hA5 in the write cycle.
   - Undefined -> rd1 shows the old value, then 32'hA5 on the next cycle.
